// File: rtl/axi4_lite_master_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_arbiter
//
// Lets two internal requesters (for example a sequencer and a host bridge)
// share a single AXI4-Lite slave. Requests are granted round-robin and only
// one AXI4-Lite read or write is in flight at any time. The slave's response
// (RDATA/RRESP or BRESP) is returned to whichever requester issued it.
//
// Parameters
//   AXI_DATA_WIDTH  data width of the AXI bus and of the requester data
//   AXI_ADDR_WIDTH  address width of the AXI bus and of the requester address
//
// Ports
//   AXI_ACLK        single clock, everything happens on the rising edge
//   AXI_ARESET      synchronous active-high reset
//   REQ_VALID[i]    requester i has a request pending
//   REQ_WRITE[i]    requester i wants a write (1) or a read (0)
//   REQ_ADDR        requester i address in slice i
//   REQ_WDATA       requester i write data in slice i
//   REQ_READY[i]    one-cycle pulse, request i has been accepted
//   RSP_VALID[i]    one-cycle pulse, response for requester i is on RSP_*
//   RSP_DATA        read data (0 after a write), held until the next response
//   RSP_RESP        captured BRESP/RRESP, held until the next response
//   M_AXI_AW*/W*/B* AXI4-Lite write address, write data and write response
//   M_AXI_AR*/R*    AXI4-Lite read address and read data
// ---------------------------------------------------------------------------
module axi4_lite_master_arbiter #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 5
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESET,

  input  logic [1:0]                  REQ_VALID,
  input  logic [1:0]                  REQ_WRITE,
  input  logic [2*AXI_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*AXI_DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]                  REQ_READY,
  output logic [1:0]                  RSP_VALID,
  output logic [AXI_DATA_WIDTH-1:0]   RSP_DATA,
  output logic [1:0]                  RSP_RESP,

  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,

  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESPOND
  } state_t;

  state_t state;
  state_t next_state;

  // Transaction context captured at grant time
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic                      grant_q;
  logic                      last_grant;

  // Write-channel bookkeeping: AW and W may finish in either order
  logic aw_done;
  logic w_done;

  // Captured response, held until the next response overwrites it
  logic [AXI_DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]                rsp_resp_q;

  // Arbitration results for the current cycle
  logic                      grant_idx;
  logic                      grant_fire;
  logic                      sel_write;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [AXI_DATA_WIDTH-1:0] sel_wdata;

  // Channel handshakes seen this cycle
  logic aw_hs;
  logic w_hs;

  // Round-robin pick: a lone requester always wins, and when both ask the
  // one that was not served last goes first. Reset leaves last_grant at 1
  // so requester 0 wins the very first contest. Grants are suppressed while
  // reset is asserted so a request is never acknowledged and then lost.
  always_comb begin
    if (REQ_VALID == 2'b11) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = REQ_VALID[1];
    end
    grant_fire = (state == IDLE) && (REQ_VALID != 2'b00) && !AXI_ARESET;
    sel_write  = REQ_WRITE[grant_idx];
    sel_addr   = grant_idx ? REQ_ADDR[2*AXI_ADDR_WIDTH-1:AXI_ADDR_WIDTH]
                           : REQ_ADDR[AXI_ADDR_WIDTH-1:0];
    sel_wdata  = grant_idx ? REQ_WDATA[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH]
                           : REQ_WDATA[AXI_DATA_WIDTH-1:0];
  end

  // A channel handshake only counts while that channel is still outstanding
  always_comb begin
    aw_hs = (state == WR_ADDR_DATA) && !aw_done && M_AXI_AWREADY;
    w_hs  = (state == WR_ADDR_DATA) && !w_done  && M_AXI_WREADY;
  end

  // State register
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one transaction at a time, always finishing with a
  // single RESPOND cycle before arbitration is allowed again
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_fire) begin
          next_state = sel_write ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          next_state = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          next_state = RESPOND;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          next_state = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          next_state = RESPOND;
        end
      end
      RESPOND: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath registers: latch the winning request, track which write
  // channels have completed, and capture the slave's response. Addresses
  // are word aligned here so the bus never sees a sub-word address.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= 2'b00;
    end else begin
      if (grant_fire) begin
        addr_q     <= {sel_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
        wdata_q    <= sel_wdata;
        grant_q    <= grant_idx;
        last_grant <= grant_idx;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
      if ((state == WR_RESP) && M_AXI_BVALID) begin
        rsp_data_q <= '0;
        rsp_resp_q <= M_AXI_BRESP;
      end
      if ((state == RD_DATA) && M_AXI_RVALID) begin
        rsp_data_q <= M_AXI_RDATA;
        rsp_resp_q <= M_AXI_RRESP;
      end
    end
  end

  // Output decode. Every VALID/READY is a pure function of state, so the
  // ready signals for B and R are low outside their own states and any
  // unsolicited BVALID/RVALID simply goes unacknowledged.
  always_comb begin
    REQ_READY     = 2'b00;
    RSP_VALID     = 2'b00;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      IDLE: begin
        REQ_READY[grant_idx] = grant_fire;
      end
      WR_ADDR_DATA: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
      end
      RD_ADDR: begin
        M_AXI_ARVALID = 1'b1;
      end
      RD_DATA: begin
        M_AXI_RREADY = 1'b1;
      end
      RESPOND: begin
        RSP_VALID[grant_q] = 1'b1;
      end
      default: begin
        REQ_READY = 2'b00;
      end
    endcase
  end

  // Address and data buses come straight from the latched request
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign RSP_DATA     = rsp_data_q;
  assign RSP_RESP     = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_master_arbiter
//
// Directed bench for axi4_lite_master_arbiter. A small behavioural
// register-file slave answers one cycle after each address/data handshake;
// address 12 always answers SLVERR with a fixed marker word.
// ---------------------------------------------------------------------------
module tb_axi4_lite_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic            AXI_ACLK = 1'b0;
  logic            AXI_ARESET;
  logic [1:0]      REQ_VALID;
  logic [1:0]      REQ_WRITE;
  logic [2*AW-1:0] REQ_ADDR;
  logic [2*DW-1:0] REQ_WDATA;
  logic [1:0]      REQ_READY;
  logic [1:0]      RSP_VALID;
  logic [DW-1:0]   RSP_DATA;
  logic [1:0]      RSP_RESP;
  logic [AW-1:0]   M_AXI_AWADDR;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  logic [AW-1:0]   M_AXI_ARADDR;
  logic            M_AXI_ARVALID;
  logic            M_AXI_ARREADY;
  logic [DW-1:0]   M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic            M_AXI_RVALID;
  logic            M_AXI_RREADY;

  int checkCount = 0;
  int errorCount = 0;

  // Slave model state
  logic [DW-1:0] mem [0:7];
  logic          awGot;
  logic          wGot;
  logic          arGot;
  logic [AW-1:0] sAwAddr;
  logic [DW-1:0] sWData;
  logic [AW-1:0] sArAddr;

  always #5 AXI_ACLK = ~AXI_ACLK;

  axi4_lite_master_arbiter #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW)
  ) dut (
    .AXI_ACLK      (AXI_ACLK),
    .AXI_ARESET    (AXI_ARESET),
    .REQ_VALID     (REQ_VALID),
    .REQ_WRITE     (REQ_WRITE),
    .REQ_ADDR      (REQ_ADDR),
    .REQ_WDATA     (REQ_WDATA),
    .REQ_READY     (REQ_READY),
    .RSP_VALID     (RSP_VALID),
    .RSP_DATA      (RSP_DATA),
    .RSP_RESP      (RSP_RESP),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  // Register-file slave: a write lands one cycle after both AW and W have
  // been seen and BVALID follows; a read answers one cycle after AR.
  // Reset also reloads the preset contents (reg 0 = 0x1234, reg 2 = 42).
  always @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= '0;
      end
      mem[0]       <= 32'h0000_1234;
      mem[2]       <= 32'd42;
      awGot        <= 1'b0;
      wGot         <= 1'b0;
      arGot        <= 1'b0;
      sAwAddr      <= '0;
      sWData       <= '0;
      sArAddr      <= '0;
      M_AXI_BVALID <= 1'b0;
      M_AXI_RVALID <= 1'b0;
      M_AXI_RDATA  <= '0;
      M_AXI_RRESP  <= 2'b00;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        awGot   <= 1'b1;
        sAwAddr <= M_AXI_AWADDR;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        wGot   <= 1'b1;
        sWData <= M_AXI_WDATA;
      end
      if (awGot && wGot) begin
        mem[sAwAddr[4:2]] <= sWData;
        awGot             <= 1'b0;
        wGot              <= 1'b0;
        M_AXI_BVALID      <= 1'b1;
      end else if (M_AXI_BVALID && M_AXI_BREADY) begin
        M_AXI_BVALID <= 1'b0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        arGot   <= 1'b1;
        sArAddr <= M_AXI_ARADDR;
      end
      if (arGot) begin
        arGot        <= 1'b0;
        M_AXI_RVALID <= 1'b1;
        if (sArAddr == 5'd12) begin
          M_AXI_RDATA <= 32'h0DEC_0DE0;
          M_AXI_RRESP <= 2'b10;
        end else begin
          M_AXI_RDATA <= mem[sArAddr[4:2]];
          M_AXI_RRESP <= 2'b00;
        end
      end else if (M_AXI_RVALID && M_AXI_RREADY) begin
        M_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [127:0] allOutputs();
    return {REQ_READY, RSP_VALID, RSP_DATA, RSP_RESP, M_AXI_AWADDR,
            M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WVALID, M_AXI_BREADY,
            M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY};
  endfunction

  // Issue one request from requester idx, check acceptance, the address
  // phase one cycle later, response latency, the response contents and
  // that RSP_VALID is a single-cycle pulse.
  task automatic applyStimulus(input string tag, input int idx, input bit wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [DW-1:0] expData, input logic [1:0] expResp,
                               input int expLatency);
    bit seen;
    int waitCycles;
    logic [1:0] expVec;
    logic [AW-1:0] alignedAddr;
    expVec = 2'b01 << idx;
    alignedAddr = {addr[AW-1:2], 2'b00};
    @(posedge AXI_ACLK); #1;
    REQ_WRITE[idx] = wr;
    REQ_ADDR[idx*AW +: AW] = addr;
    REQ_WDATA[idx*DW +: DW] = wdata;
    REQ_VALID[idx] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge AXI_ACLK);
      if (REQ_READY != 2'b00) begin
        seen = 1'b1;
      end else begin
        @(posedge AXI_ACLK); #1;
      end
    end
    checkOutput({tag, "_req_ready"}, REQ_READY, expVec);
    @(posedge AXI_ACLK); #1;
    REQ_VALID[idx] = 1'b0;
    seen = 1'b0;
    waitCycles = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge AXI_ACLK);
      waitCycles++;
      if (waitCycles == 1) begin
        if (wr) begin
          checkOutput({tag, "_aw_w_phase"},
                      {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_AWADDR, M_AXI_WDATA},
                      {1'b1, 1'b1, 1'b0, alignedAddr, wdata});
        end else begin
          checkOutput({tag, "_ar_phase"},
                      {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARADDR},
                      {1'b1, 1'b0, 1'b0, alignedAddr});
        end
      end
      if (RSP_VALID != 2'b00) begin
        seen = 1'b1;
      end
    end
    checkOutput({tag, "_latency"}, waitCycles, expLatency);
    checkOutput({tag, "_rsp"}, {RSP_VALID, RSP_RESP, RSP_DATA}, {expVec, expResp, expData});
    @(negedge AXI_ACLK);
    checkOutput({tag, "_rsp_pulse"}, RSP_VALID, 2'b00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit expG;
    bit expR;
    int grants;
    int rsps;
    int pulses;

    AXI_ARESET    = 1'b1;
    REQ_VALID     = 2'b00;
    REQ_WRITE     = 2'b00;
    REQ_ADDR      = '0;
    REQ_WDATA     = '0;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    M_AXI_ARREADY = 1'b1;
    M_AXI_BRESP   = 2'b00;
    repeat (3) @(posedge AXI_ACLK);
    #1 AXI_ARESET = 1'b0;
    @(negedge AXI_ACLK);
    checkOutput("reset_outputs", allOutputs(), 128'd0);

    // Both requesters always asking for reads of reg 0: grants alternate
    // starting with requester 0, and so do the responses.
    $display("[TB] round-robin contention");
    grants = 0;
    rsps = 0;
    expG = 1'b0;
    expR = 1'b0;
    @(posedge AXI_ACLK); #1;
    REQ_WRITE = 2'b00;
    REQ_ADDR  = '0;
    REQ_VALID = 2'b11;
    for (int cyc = 0; cyc < 200 && rsps < 8; cyc++) begin
      @(negedge AXI_ACLK);
      if (REQ_READY != 2'b00) begin
        checkOutput($sformatf("rr_grant%0d", grants), REQ_READY, expG ? 2'b10 : 2'b01);
        grants++;
        expG = ~expG;
      end
      if (RSP_VALID != 2'b00) begin
        checkOutput($sformatf("rr_rsp%0d", rsps), {RSP_VALID, RSP_RESP, RSP_DATA},
                    {(expR ? 2'b10 : 2'b01), 2'b00, 32'h0000_1234});
        rsps++;
        expR = ~expR;
      end
      @(posedge AXI_ACLK); #1;
      if (grants >= 8) begin
        REQ_VALID = 2'b00;
      end
    end
    checkOutput("rr_grant_count", grants, 8);
    checkOutput("rr_rsp_count", rsps, 8);

    $display("[TB] single write and read transactions");
    applyStimulus("wr_req0", 0, 1'b1, 5'd4, 32'hDEAD_BEEF, 32'd0, 2'b00, 4);
    checkOutput("wr_req0_mem", mem[1], 32'hDEAD_BEEF);
    applyStimulus("wr_unaligned", 1, 1'b1, 5'd7, 32'h1234_5678, 32'd0, 2'b00, 4);
    checkOutput("wr_unaligned_mem", mem[1], 32'h1234_5678);
    applyStimulus("rd_req1", 1, 1'b0, 5'd8, 32'd0, 32'd42, 2'b00, 4);

    // Write where WREADY comes three cycles after the AW handshake
    $display("[TB] write with late WREADY");
    @(posedge AXI_ACLK); #1;
    M_AXI_WREADY = 1'b0;
    REQ_WRITE[0] = 1'b1;
    REQ_ADDR[AW-1:0] = 5'd16;
    REQ_WDATA[DW-1:0] = 32'hA5A5_0F0F;
    REQ_VALID = 2'b01;
    @(negedge AXI_ACLK);
    checkOutput("slow_w_req_ready", REQ_READY, 2'b01);
    @(posedge AXI_ACLK); #1;
    REQ_VALID = 2'b00;
    @(negedge AXI_ACLK);
    checkOutput("slow_w_t1", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b110);
    @(posedge AXI_ACLK); #1;
    @(negedge AXI_ACLK);
    checkOutput("slow_w_t2", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b010);
    @(posedge AXI_ACLK); #1;
    @(negedge AXI_ACLK);
    checkOutput("slow_w_t3", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b010);
    @(posedge AXI_ACLK); #1;
    M_AXI_WREADY = 1'b1;
    @(negedge AXI_ACLK);
    checkOutput("slow_w_t4", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b010);
    @(posedge AXI_ACLK); #1;
    @(negedge AXI_ACLK);
    checkOutput("slow_w_t5", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b001);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge AXI_ACLK);
      if (RSP_VALID != 2'b00) begin
        checkOutput("slow_w_rsp", {RSP_VALID, RSP_RESP, RSP_DATA}, {2'b01, 2'b00, 32'd0});
        pulses++;
      end
    end
    checkOutput("slow_w_pulses", pulses, 1);
    checkOutput("slow_w_mem", mem[4], 32'hA5A5_0F0F);

    $display("[TB] slave error response");
    applyStimulus("rd_slverr", 1, 1'b0, 5'd12, 32'd0, 32'h0DEC_0DE0, 2'b10, 4);

    // Reset while waiting for read data, then a normal read afterwards
    $display("[TB] reset in the middle of a read");
    @(posedge AXI_ACLK); #1;
    REQ_WRITE[0] = 1'b0;
    REQ_ADDR[AW-1:0] = 5'd8;
    REQ_VALID = 2'b01;
    @(negedge AXI_ACLK);
    checkOutput("mid_rst_req_ready", REQ_READY, 2'b01);
    @(posedge AXI_ACLK); #1;
    REQ_VALID = 2'b00;
    @(negedge AXI_ACLK);
    checkOutput("mid_rst_arvalid", M_AXI_ARVALID, 1'b1);
    @(posedge AXI_ACLK); #1;
    AXI_ARESET = 1'b1;
    @(negedge AXI_ACLK);
    checkOutput("mid_rst_rready", M_AXI_RREADY, 1'b1);
    @(posedge AXI_ACLK); #1;
    AXI_ARESET = 1'b0;
    @(negedge AXI_ACLK);
    checkOutput("mid_rst_outputs", allOutputs(), 128'd0);
    applyStimulus("post_rst_rd", 0, 1'b0, 5'd8, 32'd0, 32'd42, 2'b00, 4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master_arbiter.md
Name: axi4_lite_master_arbiter

Overview:
- Shares one AXI4-Lite slave (register file) between two internal requesters using a simple request/response interface.
- Arbitrates round-robin between the requesters and runs one AXI4-Lite read or write at a time.
- Returns the slave's RDATA/RRESP or BRESP to the requester that issued the transaction.
- Sits between control FSMs (e.g. a sequencer and a host bridge) and the slave's S_AXI_* port.

Parameters:
AXI_DATA_WIDTH, 32, AXI data width and requester data width
AXI_ADDR_WIDTH, 5, AXI address width and requester address width

Ports:
AXI_ACLK  in  1  single clock; all logic on rising edge
AXI_ARESET  in  1  synchronous, active-high reset
REQ_VALID  in  2  per-requester request; bit i = requester i
REQ_WRITE  in  2  per-requester: 1 = write, 0 = read
REQ_ADDR  in  2*AXI_ADDR_WIDTH  requester i in slice i
REQ_WDATA  in  2*AXI_DATA_WIDTH  requester i in slice i
REQ_READY  out  2  one-cycle pulse: request i accepted
RSP_VALID  out  2  one-cycle pulse: response for requester i
RSP_DATA  out  AXI_DATA_WIDTH  read data; 0 for writes
RSP_RESP  out  2  captured BRESP/RRESP
M_AXI_AWADDR  out  AXI_ADDR_WIDTH  write address
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  AXI_DATA_WIDTH  write data
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
M_AXI_ARADDR  out  AXI_ADDR_WIDTH  read address
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  AXI_DATA_WIDTH
M_AXI_RRESP  in  2
M_AXI_RVALID  in  1
M_AXI_RREADY  out  1

Behaviour:
- Clock and reset: one clock (AXI_ACLK). AXI_ARESET is synchronous and active-high.
- Reset values: all VALID/READY outputs 0, RSP_DATA 0, RSP_RESP 0, state IDLE, last_grant=1 (requester 0 wins first).
- Reset mid-transaction abandons the transaction. The slave must be reset in the same cycle.
- Bus tie-offs: slave AWPROT/ARPROT are tied to 0 and WSTRB to all-ones at integration.
- Address alignment: AWADDR/ARADDR bits [1:0] are forced to 0.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- IDLE arbitration:
  - If exactly one REQ_VALID bit is set, grant that requester.
  - If both are set, grant the requester that is not last_grant.
  - On grant (cycle T): REQ_READY[g]=1 for cycle T only; latch addr/wdata/write; last_grant<=g.
  - Next state is WR_ADDR_DATA (write) or RD_ADDR (read).
- Requester rules:
  - A requester holds REQ_VALID and its fields stable until its REQ_READY pulse.
  - REQ_READY is 0 in every non-IDLE state.
  - REQ_VALID may be dropped after acceptance.
- WR_ADDR_DATA:
  - AWVALID and WVALID both rise at T+1.
  - Each drops the cycle after its own handshake. AW and W may complete in either order or together.
  - When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On the BVALID&BREADY cycle, capture BRESP into RSP_RESP and set RSP_DATA=0; go to RESPOND.
- RD_ADDR: ARVALID=1 from T+1 until the AR handshake, then go to RD_DATA.
- RD_DATA: RREADY=1. On the RVALID&RREADY cycle, capture RDATA/RRESP; go to RESPOND.
- RESPOND:
  - RSP_VALID[g]=1 for exactly one cycle; RSP_DATA/RSP_RESP hold until the next response.
  - Return to IDLE; a new grant is possible on the following cycle.
  - There is no response back-pressure.
- Unsolicited responses: BREADY/RREADY are 0 outside WR_RESP/RD_DATA. BVALID/RVALID outside those states are not acknowledged.
- Minimum latency (always-ready slave with a one-cycle response): accept at T, AXI handshake at T+1, response handshake at T+3, RSP_VALID at T+4.
- Ordering: one outstanding transaction at a time. RRESP/BRESP are passed through unmodified (SLVERR=2 included).

Test Plan:
- Req0 write addr 4, data 0xDEADBEEF, slave always ready -> REQ_READY[0] at T; AW/W handshake at T+1; RSP_VALID[0] at T+4 with RSP_RESP=0, RSP_DATA=0; slave reg 4 = 0xDEADBEEF.
- Req1 read addr 8 from slave returning 42 -> RSP_VALID[1] pulse with RSP_DATA=42, RSP_RESP=0; ARADDR=8.
- Both requesters valid every cycle, reads to addr 0 -> grants alternate 0,1,0,1 starting with 0; RSP_VALID alternates; no starvation over 8 transactions.
- Write with WREADY delayed 3 cycles after AWREADY:
  - AWVALID drops after its handshake while WVALID stays high.
  - BREADY asserts only after the W handshake.
  - Single RSP_VALID pulse.
- Read addr 12 (slave SLVERR) -> RSP_RESP=2, RSP_DATA=0x0DEC0DE0.
- AXI_ARESET asserted for 1 cycle during RD_DATA:
  - Next cycle all outputs are 0 and state is IDLE.
  - A fresh req0 read after reset completes normally, granted to requester 0.
